riscv_dmem_responder: RTL

Data-memory responder for the multi-cycle RV32I core. It accepts one load or store per handshake from the CPU memory stage and steers bytes, halfwords or words into a word-organised on-chip array. It returns sign- or zero-extended load data, or an error, after a configurable number of wait states. It is the target end of the CPU's load/store interface and sits between the core and the data SRAM.

---
 rtl/riscv_dmem_responder_pkg.sv | 18 +
 rtl/riscv_dmem_lanes.sv | 53 +++++
 rtl/riscv_dmem_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/riscv_dmem_responder_pkg.sv
// riscv_dmem_responder_pkg: shared RISC-V types for the data-memory responder
package riscv_dmem_responder_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    localparam int DMEM_WAIT_MAX = 15;

endpackage

// File: rtl/riscv_dmem_lanes.sv
// riscv_dmem_lanes: byte-lane steering for stores and extension for loads
module riscv_dmem_lanes
    import riscv_dmem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [31:0] shifted;

    // selected byte/half lands at bit 0 for the extension below
    assign shifted = rdata_raw >> {addr, 3'b000};

    // lane enables, replicated store data, extended load data and alignment check
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
        misalign  = 1'b0;
        case (size)
            BYTE: begin
                be        = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                be        = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
                misalign  = addr[0];
            end
            WORD: begin
                be        = 4'b1111;
                rdata_ext = rdata_raw;
                misalign  = addr != 2'b00;
            end
            default: begin
                be        = 4'b0000;
                rdata_ext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: wait-stated load/store target backed by a word array
module riscv_dmem_responder
    import riscv_dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > DMEM_WAIT_MAX) ? 4'(DMEM_WAIT_MAX - 1)
                                                                     : 4'(WAIT_CYCLES - 1);

    dmem_state_e state, state_next;
    logic [3:0]  cnt;

    logic        l_we;
    logic [31:0] l_addr;
    logic [1:0]  l_size;
    logic        l_unsigned;
    logic [31:0] l_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        commit;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [1:0]  cur_size;
    logic        cur_unsigned;
    logic [31:0] cur_wdata;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;
    logic        misalign;
    logic        err;

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign accept    = req_valid && req_ready;
    assign commit    = state_next == RESP && state != RESP;

    // with zero wait states the commit edge is also the accept edge, so use the live request
    assign cur_we       = req_ready ? req_we       : l_we;
    assign cur_addr     = req_ready ? req_addr     : l_addr;
    assign cur_size     = req_ready ? req_size     : l_size;
    assign cur_unsigned = req_ready ? req_unsigned : l_unsigned;
    assign cur_wdata    = req_ready ? req_wdata    : l_wdata;

    assign idx = cur_addr[AW+1:2];
    assign err = misalign || cur_size == 2'b11 || (cur_addr >> (AW + 2)) != 32'h0;

    riscv_dmem_lanes u_lanes (
        .size        (cur_size),
        .addr        (cur_addr[1:0]),
        .is_unsigned (cur_unsigned),
        .wdata       (cur_wdata),
        .rdata_raw   (mem[idx]),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .rdata_ext   (rdata_ext),
        .misalign    (misalign)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // wait-state counter: loads on entry to WAIT, counts down while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       cnt <= 4'd0;
        else if (state_next == WAIT && state != WAIT) cnt <= WAIT_LOAD;
        else if (state == WAIT && cnt != 4'd0)        cnt <= cnt - 4'd1;
    end

    // request latch captured on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_we       <= 1'b0;
            l_addr     <= 32'h0;
            l_size     <= 2'b00;
            l_unsigned <= 1'b0;
            l_wdata    <= 32'h0;
        end else if (accept) begin
            l_we       <= req_we;
            l_addr     <= req_addr;
            l_size     <= req_size;
            l_unsigned <= req_unsigned;
            l_wdata    <= req_wdata;
        end
    end

    // response registers, updated on the edge that enters RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_rdata <= (err || cur_we) ? 32'h0 : rdata_ext;
            rsp_err   <= err;
        end
    end

    // array write on the edge that enters RESP; contents are not reset
    always_ff @(posedge clk) begin
        if (commit && cur_we && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
    end

endmodule
